// File: rtl/bayer_pkg.sv
// Shared constants and types for the Bayer capture/demosaic front end.
package bayer_pkg;
    localparam int DEF_DATA_W     = 12;
    localparam int DEF_LINE_WIDTH = 1280;
    localparam int CNT_W          = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } cap_state_e;

    // Row parity selects the Bayer row type; the G2 pixel sits on odd columns of B/G2 rows.
    localparam logic ROW_G1R = 1'b0;
    localparam logic ROW_BG2 = 1'b1;
    localparam logic COL_G2  = 1'b1;
endpackage

// File: rtl/bayer_line_buffer.sv
// One-line buffer holding the G1/R row; synchronous read plus a one-read delayed tap for rX-1.
module bayer_line_buffer #(
    parameter int DEPTH  = 1280,
    parameter int DATA_W = 12,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [DATA_W-1:0] rdata_dly_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_dly_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) begin
            rdata_q     <= mem_q[raddr_i];
            rdata_dly_q <= rdata_q;
        end
    end

    assign rdata_o     = rdata_q;
    assign rdata_dly_o = rdata_dly_q;
endmodule

// File: rtl/bayer_frame_capture.sv
// Start/stop gated Bayer frame capture; emits one RGB pixel per 2x2 quad, 3 clocks after the G2 sample.
module bayer_frame_capture
    import bayer_pkg::*;
#(
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic [DATA_W-1:0] iData,
    input  logic              iFval,
    input  logic              iLval,
    input  logic              iStart,
    input  logic              iEnd,
    output logic [DATA_W-1:0] oRed,
    output logic [DATA_W-1:0] oGreen,
    output logic [DATA_W-1:0] oBlue,
    output logic              oDval,
    output logic [15:0]       oX_Cont,
    output logic [15:0]       oY_Cont,
    output logic              oFval,
    output logic [31:0]       oFrameCount,
    output logic              oOverflow
);
    localparam int               AW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LW = CNT_W'(LINE_WIDTH);

    logic [DATA_W-1:0] mData_q;
    logic              mFval_q, mLval_q, fval_prev_q, lval_prev_q;
    logic              frame_start, frame_end, lval_fall;
    cap_state_e        state_q, state_d;
    logic              stop_q, stop_d, cap_en;
    logic [CNT_W-1:0]  rX_q, rX_d, rY_q, rY_d, px_x, px_y;
    logic              pix, in_range, wr_en, rd_en, quad;
    logic [DATA_W-1:0] prev_q, rd_data, rd_dly;
    logic              s1_vld_q, s2_vld_q, dval_q, ovf_q;
    logic [DATA_W-1:0] s1_g2_q, s1_b_q, s2_r_q, s2_g_q, s2_b_q;
    logic [DATA_W-1:0] red_q, green_q, blue_q;
    logic [CNT_W-1:0]  s1_x_q, s1_y_q, s2_x_q, s2_y_q, x_q, y_q;
    logic [DATA_W:0]   g_sum;
    logic [2:0]        fv_pipe_q;
    logic [31:0]       fc_q;

    assign frame_start = mFval_q & ~fval_prev_q;
    assign frame_end   = ~mFval_q & fval_prev_q;
    assign lval_fall   = ~mLval_q & lval_prev_q;

    always_comb begin
        state_d = state_q;
        stop_d  = stop_q;
        unique case (state_q)
            IDLE:    if (iStart && !iEnd) state_d = ARMED;
            ARMED: begin
                if (iEnd)             state_d = IDLE;
                else if (frame_start) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (iEnd) stop_d = 1'b1;
                if (frame_end && (stop_q || iEnd)) begin
                    state_d = IDLE;
                    stop_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Using the next state lets a pixel on the frame-start cycle itself be captured.
    assign cap_en   = (state_d == CAPTURE);
    assign pix      = mFval_q & mLval_q & cap_en;
    assign px_x     = frame_start ? '0 : rX_q;
    assign px_y     = frame_start ? '0 : rY_q;
    assign in_range = (px_x < LW);
    assign wr_en    = pix & in_range & (px_y[0] == ROW_G1R);
    assign rd_en    = pix & in_range & (px_y[0] == ROW_BG2);
    assign quad     = rd_en & (px_x[0] == COL_G2);

    always_comb begin
        rX_d = rX_q;
        rY_d = rY_q;
        if (cap_en) begin
            if (frame_start) begin
                rX_d = '0;
                rY_d = '0;
            end
            if (pix && in_range) rX_d = px_x + 1'b1;
            if (lval_fall) begin
                rX_d = '0;
                rY_d = px_y + 1'b1;
            end
        end
    end

    bayer_line_buffer #(.DEPTH(LINE_WIDTH), .DATA_W(DATA_W), .AW(AW)) u_lbuf (
        .clk_i       (iClk),
        .we_i        (wr_en),
        .waddr_i     (px_x[AW-1:0]),
        .wdata_i     (mData_q),
        .re_i        (rd_en),
        .raddr_i     (px_x[AW-1:0]),
        .rdata_o     (rd_data),
        .rdata_dly_o (rd_dly)
    );

    assign g_sum = {1'b0, rd_dly} + {1'b0, s1_g2_q};

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            mData_q     <= '0;
            mFval_q     <= 1'b0;
            mLval_q     <= 1'b0;
            fval_prev_q <= 1'b0;
            lval_prev_q <= 1'b0;
            state_q     <= IDLE;
            stop_q      <= 1'b0;
            rX_q        <= '0;
            rY_q        <= '0;
            prev_q      <= '0;
            s1_vld_q    <= 1'b0;
            s1_g2_q     <= '0;
            s1_b_q      <= '0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s2_vld_q    <= 1'b0;
            s2_r_q      <= '0;
            s2_g_q      <= '0;
            s2_b_q      <= '0;
            s2_x_q      <= '0;
            s2_y_q      <= '0;
            dval_q      <= 1'b0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            fv_pipe_q   <= '0;
            fc_q        <= '0;
            ovf_q       <= 1'b0;
        end else begin
            mData_q     <= iData;
            mFval_q     <= iFval;
            mLval_q     <= iLval;
            fval_prev_q <= mFval_q;
            lval_prev_q <= mLval_q;
            state_q     <= state_d;
            stop_q      <= stop_d;
            rX_q        <= rX_d;
            rY_q        <= rY_d;
            if (pix) prev_q <= mData_q;
            if (pix && !in_range) ovf_q <= 1'b1;
            if (frame_end && state_q == CAPTURE) fc_q <= fc_q + 32'd1;
            fv_pipe_q <= {fv_pipe_q[1:0], mFval_q & cap_en};

            s1_vld_q <= quad;
            if (quad) begin
                s1_g2_q <= mData_q;
                s1_b_q  <= prev_q;
                s1_x_q  <= px_x >> 1;
                s1_y_q  <= px_y >> 1;
            end
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_r_q <= rd_data;
                s2_g_q <= g_sum[DATA_W:1];
                s2_b_q <= s1_b_q;
                s2_x_q <= s1_x_q;
                s2_y_q <= s1_y_q;
            end
            dval_q <= s2_vld_q;
            if (s2_vld_q) begin
                red_q   <= s2_r_q;
                green_q <= s2_g_q;
                blue_q  <= s2_b_q;
                x_q     <= s2_x_q;
                y_q     <= s2_y_q;
            end
        end
    end

    assign oRed        = red_q;
    assign oGreen      = green_q;
    assign oBlue       = blue_q;
    assign oDval       = dval_q;
    assign oX_Cont     = x_q;
    assign oY_Cont     = y_q;
    assign oFval       = fv_pipe_q[2];
    assign oFrameCount = fc_q;
    assign oOverflow   = ovf_q;
endmodule

// File: tb/tb_bayer_frame_capture.sv
// Directed/random frame sequences checked against a per-quad arithmetic model of the demosaic.
module tb_bayer_frame_capture;
    localparam int LW = 8;
    localparam int DW = 12;

    logic          iClk = 1'b0, iRst_n = 1'b0;
    logic [DW-1:0] iData = '0;
    logic          iFval = 1'b0, iLval = 1'b0, iStart = 1'b0, iEnd = 1'b0;
    logic [DW-1:0] oRed, oGreen, oBlue;
    logic          oDval, oFval, oOverflow;
    logic [15:0]   oX_Cont, oY_Cont;
    logic [31:0]   oFrameCount;

    bayer_frame_capture #(.LINE_WIDTH(LW), .DATA_W(DW)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iData(iData), .iFval(iFval), .iLval(iLval),
        .iStart(iStart), .iEnd(iEnd), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
        .oDval(oDval), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oFval(oFval),
        .oFrameCount(oFrameCount), .oOverflow(oOverflow)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    typedef struct packed {
        logic [35:0] rgb;
        logic [31:0] xy;
        int          cyc;
    } pix_t;

    pix_t gotq[$];
    pix_t expq[$];
    int   ofv_rise = -1;
    logic ofv_prev = 1'b0;
    int   img  [0:7][0:15];
    int   tcyc [0:7][0:15];
    int   n_chk = 0, n_pass = 0, exp_fc = 0;

    always @(negedge iClk) begin
        if (oDval === 1'b1)
            gotq.push_back('{rgb: {oRed, oGreen, oBlue}, xy: {oX_Cont, oY_Cont}, cyc: cyc});
        if (oFval === 1'b1 && ofv_prev !== 1'b1) ofv_rise = cyc;
        ofv_prev = oFval;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic fill_random(input int rows, input int cols);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++) img[r][c] = $urandom_range(4095);
    endtask

    task automatic fill_directed();
        int row0 [4] = '{100, 200, 102, 202};
        int row1 [4] = '{300, 104, 302, 106};
        for (int c = 0; c < 4; c++) begin
            img[0][c] = row0[c];
            img[1][c] = row1[c];
        end
    endtask

    task automatic pulse(input logic s, input logic e);
        @(negedge iClk); iStart = s; iEnd = e;
        @(negedge iClk); iStart = 1'b0; iEnd = 1'b0;
    endtask

    // Drives one frame; when captured, every odd-row odd-column pixel inside the line width yields one quad.
    task automatic send_frame(input int rows, input int cols, input bit cap_in,
                              input int start_row, input int end_row, input int rst_row);
        bit cap;
        int fcyc;
        cap = cap_in;
        ofv_rise = -1;
        repeat (2) begin @(negedge iClk); iFval = 1'b0; iLval = 1'b0; end
        @(negedge iClk); iFval = 1'b1; fcyc = cyc;
        @(negedge iClk);
        for (int r = 0; r < rows; r++) begin
            for (int g = 0; g < 3; g++) begin
                @(negedge iClk);
                iLval  = 1'b0;
                iStart = (g == 0 && r == start_row) || (g == 2 && r == rst_row);
                iEnd   = (g == 0 && r == end_row);
                if (r == rst_row && g == 0) begin
                    iRst_n = 1'b0;
                    #1;
                    check("rst_mid flags", {oDval, oFval, oOverflow}, 3'b000);
                    check("rst_mid fcount", oFrameCount, 0);
                    check("rst_mid rgb", {oRed, oGreen, oBlue}, 0);
                    check("rst_mid xy", {oX_Cont, oY_Cont}, 0);
                    cap = 1'b0;
                    exp_fc = 0;
                end
                if (r == rst_row && g == 1) iRst_n = 1'b1;
            end
            for (int c = 0; c < cols; c++) begin
                @(negedge iClk);
                iStart = 1'b0; iEnd = 1'b0;
                iLval = 1'b1; iData = DW'(img[r][c]); tcyc[r][c] = cyc;
            end
        end
        @(negedge iClk); iLval = 1'b0;
        repeat (2) @(negedge iClk);
        iFval = 1'b0;
        repeat (8) @(negedge iClk);
        if (cap) begin
            for (int y = 1; y < rows; y += 2)
                for (int x = 1; x < cols && x < LW; x += 2) begin
                    pix_t e;
                    e.rgb = {DW'(img[y-1][x]), DW'((img[y-1][x-1] + img[y][x]) / 2), DW'(img[y][x-1])};
                    e.xy  = {16'(x / 2), 16'(y / 2)};
                    e.cyc = tcyc[y][x] + 4;
                    expq.push_back(e);
                end
            exp_fc++;
        end
        if (rst_row < 0) check("fval_rise", 64'(ofv_rise), cap ? 64'(fcyc + 4) : 64'(-1));
    endtask

    task automatic check_frame(input string tag);
        check({tag, " n_out"}, 64'(gotq.size()), 64'(expq.size()));
        for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
            check({tag, " rgb"}, 64'(gotq[i].rgb), 64'(expq[i].rgb));
            check({tag, " xy"}, 64'(gotq[i].xy), 64'(expq[i].xy));
            check({tag, " latency"}, 64'(gotq[i].cyc), 64'(expq[i].cyc));
        end
        check({tag, " fcount"}, 64'(oFrameCount), 64'(exp_fc));
        gotq.delete();
        expq.delete();
    endtask

    initial begin
        repeat (3) @(negedge iClk);
        check("reset flags", {oDval, oFval, oOverflow}, 3'b000);
        check("reset fcount", oFrameCount, 0);
        check("reset rgb", {oRed, oGreen, oBlue}, 0);
        check("reset xy", {oX_Cont, oY_Cont}, 0);
        iRst_n = 1'b1;

        fill_directed();
        send_frame(2, 4, 1'b0, -1, -1, -1);
        check_frame("unarmed");

        pulse(1'b1, 1'b0);
        send_frame(2, 4, 1'b1, -1, -1, -1);
        check("single n", 64'(gotq.size()), 2);
        for (int i = 0; i < gotq.size() && i < 2; i++) begin
            logic [35:0] want;
            want = (i == 0) ? {12'd200, 12'd102, 12'd300} : {12'd202, 12'd104, 12'd302};
            check("single rgb const", 64'(gotq[i].rgb), 64'(want));
            check("single xy const", 64'(gotq[i].xy), 64'({16'(i), 16'd0}));
        end
        check_frame("single");

        for (int f = 0; f < 3; f++) begin
            fill_random(4, 8);
            send_frame(4, 2 * $urandom_range(1, 4), 1'b1, (f == 1) ? 2 : -1, -1, -1);
            check_frame("random");
        end
        check("no overflow yet", oOverflow, 1'b0);

        fill_random(4, 8);
        send_frame(4, 8, 1'b1, -1, 1, -1);
        check_frame("stop frame");
        fill_random(2, 8);
        send_frame(2, 8, 1'b0, -1, -1, -1);
        check_frame("after stop");

        pulse(1'b1, 1'b1);
        fill_random(2, 8);
        send_frame(2, 8, 1'b0, -1, -1, -1);
        check_frame("start+end");

        pulse(1'b1, 1'b0);
        fill_random(2, 10);
        send_frame(2, 10, 1'b1, -1, -1, -1);
        check("overflow set", oOverflow, 1'b1);
        check_frame("overflow");
        fill_random(2, 6);
        send_frame(2, 6, 1'b1, -1, -1, -1);
        check("overflow sticky", oOverflow, 1'b1);
        check_frame("post overflow");

        fill_random(4, 8);
        send_frame(4, 8, 1'b1, -1, -1, 1);
        check_frame("reset frame");
        fill_random(4, 6);
        send_frame(4, 6, 1'b1, -1, -1, -1);
        check_frame("after reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bayer_frame_capture.md
# bayer_frame_capture

Front-end capture and demosaic stage for the camera pipeline. It sits between the raw CCD sensor interface and the grayscale/histogram/threshold display path. It qualifies raw 12-bit Bayer pixels with the sensor FVAL/LVAL strobes and gates capture with start/stop controls. It reconstructs one RGB pixel per 2x2 Bayer quad and emits 12-bit R/G/B with a data valid, the downsampled X/Y coordinates and a frame-valid flag, all in the form the downstream display top consumes.

## Interface
Parameters:
- LINE_WIDTH, 1280: raw pixels per sensor line; must be even. Output width is LINE_WIDTH/2.
- DATA_W, 12: raw and colour component width.

Ports:
- iClk  in  1  pixel clock; single clock domain.
- iRst_n  in  1  reset, asynchronous, active-low.
- iData  in  DATA_W  raw Bayer pixel.
- iFval  in  1  sensor frame valid.
- iLval  in  1  sensor line valid. A pixel is present when iFval and iLval are both high.
- iStart  in  1  single-cycle pulse: arm capture.
- iEnd  in  1  single-cycle pulse: stop after the current frame.
- oRed, oGreen, oBlue  out  DATA_W  reconstructed colour.
- oDval  out  1  colour/coordinate valid, one cycle per output pixel.
- oX_Cont, oY_Cont  out  16  output-pixel coordinates.
- oFval  out  1  captured-frame valid, aligned to the data path.
- oFrameCount  out  32  completed captured frames.
- oOverflow  out  1  sticky: a line exceeded LINE_WIDTH pixels.

## Operation
- Input register stage: iData, iFval and iLval are registered to mData, mFval and mLval. All logic below uses the registered signals.
- Frame start is mFval rising. Frame end is mFval falling.
- Control FSM, with states IDLE, ARMED and CAPTURE:
  - IDLE to ARMED on iStart.
  - ARMED to CAPTURE on frame start.
  - CAPTURE to IDLE on frame end if a stop is pending.
  - iStart in ARMED or CAPTURE is ignored.
  - iEnd in ARMED returns to IDLE immediately.
  - iEnd in CAPTURE sets stop_pending. The current frame completes, then the FSM goes to IDLE.
  - iStart and iEnd in the same cycle: iEnd wins.
- Partial frames are never captured. ARMED always waits for a fresh mFval rise.
- Raw counters, active only in CAPTURE:
  - rX increments per pixel (mFval and mLval).
  - rX clears on mLval falling. At the same time, rY increments.
  - rX and rY clear on frame start.
- Overflow: a pixel with rX >= LINE_WIDTH is dropped, meaning it is neither written nor output, and oOverflow sets. oOverflow clears only on reset.
- Bayer pattern: even rows are G1,R,G1,R,...; odd rows are B,G2,B,G2,...
- Even rows: each pixel is written to the line buffer at address rX. No output is produced.
- Odd rows, odd rX (the G2 pixel):
  - R = line_buffer[rX]
  - G1 = line_buffer[rX-1]
  - B = previous pixel
  - G2 = current pixel
- Outputs for that quad:
  - oRed = R
  - oBlue = B
  - oGreen = (G1+G2)>>1, using a DATA_W+1 bit sum; truncate, no rounding.
  - oX_Cont = rX>>1
  - oY_Cont = rY>>1
- oFrameCount increments on each frame end while in CAPTURE. It wraps from 2^32-1 to 0.

## Timing
- Reset values:
  - All outputs are 0, including oOverflow and oFrameCount.
  - FSM is in IDLE.
  - Counters are 0.
  - Line buffer contents are don't-care.
- Latency: oDval, colours and coordinates appear 3 clocks after the iClk edge that samples the G2 pixel on iData. The stages are input register, line-buffer synchronous read, and output register.
- oDval is high for exactly 1 cycle per quad. With continuous iLval it is high every other cycle on odd rows and never high on even rows.
- oFval equals mFval gated by (state==CAPTURE), delayed so that it rises 3 clocks after the iFval rise that starts the frame and falls 3 clocks after the corresponding fall.
- Reset asserted mid-frame: outputs clear asynchronously. After release the block sits in IDLE until a new iStart.

## Structure
- Package bayer_pkg holds:
  - DATA_W and the default LINE_WIDTH.
  - The state enum {IDLE, ARMED, CAPTURE}.
  - The Bayer phase constants.
- Sub-module bayer_line_buffer: LINE_WIDTH x DATA_W simple dual-port RAM with synchronous read.
  - Writes happen only on even rows and reads only on odd rows, so there is no read/write collision.
  - The rX-1 tap is a one-register delay of the read data.

## Test plan
- Frame before arming: reset, run a 4x2-pixel frame with no iStart -> oDval never asserts and oFrameCount=0.
- Single frame: iStart, then a frame with row0 = 100,200,102,202 and row1 = 300,104,302,106 -> two outputs (R,G,B) = (200,102,300) at (0,0) and (202,104,302) at (1,0). Each comes 3 clocks after its G2 sample. oFrameCount=1 after frame end.
- Stop: iEnd in mid-frame -> the frame completes, oFrameCount increments once, and the following frame produces no oDval.
- Simultaneous pulses: iStart and iEnd in the same cycle from IDLE -> stays in IDLE with no capture. iStart during CAPTURE -> no effect.
- Overflow: a line of LINE_WIDTH+2 pixels -> oOverflow=1 sticky and only LINE_WIDTH/2 outputs on that row pair.
- Reset mid-frame: assert iRst_n low during row 1 -> all outputs 0 immediately. After release and iStart, capture begins only on the next iFval rise.
